// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: shared immediate-extension unit for the MIPS datapath.
// Two requesters (0 = decode, 1 = branch/address unit) compete round-robin for
// a single-entry output register holding the extended immediate.
// Optional feature macro: IMM_ZEXT_EN adds per-requester zero-extend selects.
module imm_ext_arbiter #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_imm,
`ifdef IMM_ZEXT_EN
  input  logic             req0_zext,
`endif
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_imm,
`ifdef IMM_ZEXT_EN
  input  logic             req1_zext,
`endif
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_src,
  output logic             busy
);

  // Width sanity: extension needs at least one bit of headroom
  if (IN_W < 1 || IN_W >= OUT_W) begin : gBadParams
    $fatal(1, "imm_ext_arbiter: IN_W must satisfy 1 <= IN_W < OUT_W");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             lastGrant_q, lastGrant_d;

  logic             canLoad;
  logic             grantSel;
  logic             fire;
  logic [IN_W-1:0]  selImm;
  logic             selZext;
  logic [OUT_W-1:0] extImm;

  // Round-robin pick and extension of the winning immediate
  always_comb begin
    canLoad  = (state_q == EMPTY) || out_ready;
    grantSel = 1'b0;
    if (req0_valid && req1_valid) begin
      grantSel = ~lastGrant_q;
    end else if (req1_valid) begin
      grantSel = 1'b1;
    end
    fire   = canLoad && (req0_valid || req1_valid);
    selImm = grantSel ? req1_imm : req0_imm;
`ifdef IMM_ZEXT_EN
    selZext = grantSel ? req1_zext : req0_zext;
`else
    selZext = 1'b0;
`endif
    if (selZext) begin
      extImm = {{(OUT_W-IN_W){1'b0}}, selImm};
    end else begin
      extImm = {{(OUT_W-IN_W){selImm[IN_W-1]}}, selImm};
    end
  end

  // Readys are forced low while reset is held so nothing is accepted in reset
  always_comb begin
    req0_ready = rst && fire && !grantSel;
    req1_ready = rst && fire && grantSel;
  end

  // Next-state: load on grant (also covers drain+load with no bubble), else drain
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    src_d       = src_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      EMPTY: begin
        if (fire) begin
          state_d     = FULL;
          data_d      = extImm;
          src_d       = grantSel;
          lastGrant_d = grantSel;
        end
      end
      FULL: begin
        if (fire) begin
          data_d      = extImm;
          src_d       = grantSel;
          lastGrant_d = grantSel;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; lastGrant resets to 1 so port 0 wins the first contest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      src_q       <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      src_q       <= src_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Output register drives the consumer side directly
  always_comb begin
    out_valid = (state_q == FULL);
    busy      = (state_q == FULL);
    out_data  = data_q;
    out_src   = src_q;
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: scoreboard bench for imm_ext_arbiter.
// Honors IMM_ZEXT_EN to exercise the zero-extend selects.
module tb_imm_ext_arbiter;

  localparam int IN_W  = 4;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0;
  logic [IN_W-1:0]  req0_imm = '0;
  logic             req0_zext = 1'b0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [IN_W-1:0]  req1_imm = '0;
  logic             req1_zext = 1'b0;
  logic             req1_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_src;
  logic             busy;

  int totalChecks = 0;
  int badChecks   = 0;

  logic        mValid = 1'b0;
  logic        mLast  = 1'b1;
  logic [16:0] expQ[$];

  imm_ext_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_imm  (req0_imm),
`ifdef IMM_ZEXT_EN
    .req0_zext (req0_zext),
`endif
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_imm  (req1_imm),
`ifdef IMM_ZEXT_EN
    .req1_zext (req1_zext),
`endif
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] extendRef(input logic [3:0] imm, input logic z);
    if (z) return {12'h000, imm};
    return {{12{imm[3]}}, imm};
  endfunction

  // Drive one cycle of inputs, then return just after the following edge
  task automatic applyStimulus(input logic v0, input logic [3:0] i0, input logic z0,
                               input logic v1, input logic [3:0] i1, input logic z1,
                               input logic ordy);
    req0_valid = v0; req0_imm = i0; req0_zext = z0;
    req1_valid = v1; req1_imm = i1; req1_zext = z1;
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predict readys from the reference model, compare the output
  // register against the queue head, then advance the model as the edge will
  always @(negedge clk) begin
    logic expCan, expG, expFire;
    if (!rst) begin
      mValid = 1'b0;
      mLast  = 1'b1;
      expQ.delete();
    end else begin
      expCan = !mValid || out_ready;
      if (req0_valid && req1_valid) expG = ~mLast;
      else                          expG = req1_valid;
      expFire = expCan && (req0_valid || req1_valid);
      checkOutput("ready0", 32'(req0_ready), 32'(expFire && !expG));
      checkOutput("ready1", 32'(req1_ready), 32'(expFire && expG));
      checkOutput("oneReady", 32'(req0_ready && req1_ready), 32'(0));
      checkOutput("valid", 32'(out_valid), 32'(mValid));
      checkOutput("busy", 32'(busy), 32'(mValid));
      if (mValid && expQ.size() > 0) begin
        checkOutput("data", 32'(out_data), 32'(expQ[0][15:0]));
        checkOutput("src", 32'(out_src), 32'(expQ[0][16]));
      end
      if (mValid && out_ready) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        mValid = 1'b0;
      end
      if (expFire) begin
        expQ.push_back({expG, extendRef(expG ? req1_imm : req0_imm,
                                        expG ? req1_zext : req0_zext)});
        mValid = 1'b1;
        mLast  = expG;
      end
    end
  end

  initial begin
    logic acc0, acc1;
    logic [3:0] seqImm [4];
    logic [15:0] seqExp [4];
    seqImm = '{4'b1000, 4'b1111, 4'b1001, 4'b0000};
    seqExp = '{16'hFFF8, 16'hFFFF, 16'hFFF9, 16'h0000};

    // Reset state, with a valid request to show readys stay low in reset
    req0_valid = 1'b1;
    #2;
    checkOutput("rstValid", 32'(out_valid), 32'(0));
    checkOutput("rstData", 32'(out_data), 32'(0));
    checkOutput("rstSrc", 32'(out_src), 32'(0));
    checkOutput("rstReady0", 32'(req0_ready), 32'(0));
    checkOutput("rstReady1", 32'(req1_ready), 32'(0));
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Port 0 alone
    applyStimulus(1, 4'b0001, 0, 0, 4'h0, 0, 1);
    checkOutput("t1data", 32'(out_data), 32'h0001);
    checkOutput("t1src", 32'(out_src), 32'(0));
    checkOutput("t1valid", 32'(out_valid), 32'(1));

    // Port 1 alone, back-to-back
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4'h0, 0, 1, seqImm[i], 0, 1);
      checkOutput("t2data", 32'(out_data), 32'(seqExp[i]));
      checkOutput("t2src", 32'(out_src), 32'(1));
    end
    applyStimulus(0, 4'h0, 0, 0, 4'h0, 0, 1);

    // Fresh reset, then both ports contend: 0 first, then alternate
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'b0011, 0, 1, 4'b1100, 0, 1);
      checkOutput("t3src", 32'(out_src), 32'(i % 2));
      checkOutput("t3data", 32'(out_data), (i % 2 == 0) ? 32'h0003 : 32'hFFFC);
    end
    applyStimulus(0, 4'h0, 0, 0, 4'h0, 0, 1);

    // Backpressure holds data, then releases with no bubble
    applyStimulus(1, 4'b1010, 0, 0, 4'h0, 0, 1);
    checkOutput("t4load", 32'(out_data), 32'hFFFA);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0101, 0, 0, 4'h0, 0, 0);
      checkOutput("t4hold", 32'(out_data), 32'hFFFA);
      checkOutput("t4ready", 32'(req0_ready), 32'(0));
    end
    applyStimulus(1, 4'b0101, 0, 0, 4'h0, 0, 1);
    checkOutput("t4next", 32'(out_data), 32'h0005);
    checkOutput("t4valid", 32'(out_valid), 32'(1));

    // Async reset between edges while full, then port 0 wins first
    applyStimulus(0, 4'h0, 0, 1, 4'b0111, 0, 0);
    checkOutput("t5full", 32'(out_valid), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5valid", 32'(out_valid), 32'(0));
    checkOutput("t5data", 32'(out_data), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1, 4'b0110, 0, 1, 4'b0111, 0, 1);
    checkOutput("t5src", 32'(out_src), 32'(0));
    checkOutput("t5first", 32'(out_data), 32'h0006);

`ifdef IMM_ZEXT_EN
    // Zero-extend select is latched with the data
    applyStimulus(1, 4'b1000, 1, 0, 4'h0, 0, 1);
    checkOutput("t6zext", 32'(out_data), 32'h0008);
    applyStimulus(1, 4'b1000, 0, 0, 4'h0, 0, 1);
    checkOutput("t6sext", 32'(out_data), 32'hFFF8);
`endif

    // Random traffic respecting hold-until-ready
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_imm   = 4'($urandom_range(0, 15));
`ifdef IMM_ZEXT_EN
        req0_zext  = 1'($urandom_range(0, 1));
`endif
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_imm   = 4'($urandom_range(0, 15));
`ifdef IMM_ZEXT_EN
        req1_zext  = 1'($urandom_range(0, 1));
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    @(negedge clk);
    acc0 = req0_ready;
    acc1 = req1_ready;
    @(posedge clk); #1;
    req0_valid = req0_valid && !acc0;
    req1_valid = req1_valid && !acc1;
    out_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    checkOutput("drained", 32'(out_valid), 32'(0));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
